// File: rtl/vec_mul_pkg.sv
// Shared definitions for the vec_mul job sequencer and the vec_mul datapath.
// Holds the default address widths, the result-path latency that both sides
// must agree on, and the sequencer state encoding.
package vec_mul_pkg;

    localparam int unsigned DEF_ADDRESSSIZE      = 10;
    localparam int unsigned DEF_ADDRESSSIZE_FIFO = 2;
    localparam int unsigned DEF_PIPE_LAT         = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD0 = 3'd1,
        ST_WLOAD1 = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/vec_mul_sequencer_if.sv
// Job-control and memory-side signal bundle of the vec_mul sequencer.
//   start / cfg_*          : job request and its configuration
//   busy / done            : job status
//   wfifo_addr / weight_reload        : weight-SRAM read and multiplier weight latch
//   ub_rd_addr / ub_rd_valid          : unified-buffer read stream
//   res_we / res_addr                 : results-SRAM write port
// master = job requester / memory side, slave = the sequencer.
interface vec_mul_sequencer_if
    import vec_mul_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE      = DEF_ADDRESSSIZE,
    parameter int unsigned ADDRESSSIZE_fifo = DEF_ADDRESSSIZE_FIFO
) ();

    logic                        start;
    logic [ADDRESSSIZE-1:0]      cfg_ub_base;
    logic [ADDRESSSIZE-1:0]      cfg_len;
    logic [ADDRESSSIZE_fifo-1:0] cfg_w_slot;
    logic                        cfg_skip_wload;

    logic                        busy;
    logic                        done;
    logic [ADDRESSSIZE_fifo-1:0] wfifo_addr;
    logic                        weight_reload;
    logic [ADDRESSSIZE-1:0]      ub_rd_addr;
    logic                        ub_rd_valid;
    logic                        res_we;
    logic [ADDRESSSIZE-1:0]      res_addr;

    modport master (
        output start, cfg_ub_base, cfg_len, cfg_w_slot, cfg_skip_wload,
        input  busy, done, wfifo_addr, weight_reload,
        input  ub_rd_addr, ub_rd_valid, res_we, res_addr
    );

    modport slave (
        input  start, cfg_ub_base, cfg_len, cfg_w_slot, cfg_skip_wload,
        output busy, done, wfifo_addr, weight_reload,
        output ub_rd_addr, ub_rd_valid, res_we, res_addr
    );

endinterface

// File: rtl/vec_mul_sequencer_valid_delay_line.sv
// DEPTH-deep 1-bit shift register that turns a UB read strobe into the
// matching results-SRAM write strobe.
//   clk, clr      : clock, synchronous active-high clear
//   in_valid      : strobe entering the line
//   out_valid     : in_valid delayed by exactly DEPTH cycles (registered)
//   any_valid_c   : a strobe is still in flight that has not reached out_valid
module valid_delay_line
    import vec_mul_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic clr,
    input  logic in_valid,
    output logic out_valid,
    output logic any_valid_c
);

    logic [DEPTH-1:0] sr_q;

    // Shift register; bit 0 is the youngest entry.
    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= in_valid;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign out_valid = sr_q[DEPTH-1];

    // The last stage is already presented on out_valid this cycle, so it does
    // not count as pending; the entering strobe does.
    always_comb begin
        any_valid_c = in_valid;
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            any_valid_c = any_valid_c | sr_q[i];
        end
    end

endmodule

// File: rtl/vec_mul_sequencer.sv
// Control FSM for one vector-multiply job on the vec_mul datapath: optional
// weight load from the weight SRAM, a run of UB reads, results-SRAM writes
// delayed by PIPE_LAT, then a one-cycle done pulse.
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : vec_mul_sequencer_if.slave (job control, weight/UB/results ports)
module vec_mul_sequencer
    import vec_mul_pkg::*;
#(
    parameter int unsigned ADDRESSSIZE      = DEF_ADDRESSSIZE,
    parameter int unsigned ADDRESSSIZE_fifo = DEF_ADDRESSSIZE_FIFO,
    parameter int unsigned PIPE_LAT         = DEF_PIPE_LAT
) (
    input  logic                clk,
    input  logic                rst,
    vec_mul_sequencer_if.slave  bus
);

    localparam int unsigned AW = ADDRESSSIZE;
    localparam int unsigned WW = ADDRESSSIZE_fifo;

    seq_state_t     state_q, state_d;

    logic [AW-1:0]  base_q, len_q, rd_cnt_q;
    logic [WW-1:0]  slot_q;
    logic [AW-1:0]  res_addr_q;

    logic           accept_c;
    logic [AW-1:0]  base_c, len_c, cnt_c;
    logic [WW-1:0]  slot_c;
    logic           drain_pending_c;
    logic           res_we_c;

    // Next values of the registered outputs.
    logic           busy_d, done_d, weight_reload_d, ub_rd_valid_d;
    logic [WW-1:0]  wfifo_addr_d;
    logic [AW-1:0]  ub_rd_addr_d;

    logic           busy_q, done_q, weight_reload_q, ub_rd_valid_q;
    logic [WW-1:0]  wfifo_addr_q;
    logic [AW-1:0]  ub_rd_addr_q;

    assign accept_c = (state_q == ST_IDLE) && bus.start;

    // In the accept cycle the job configuration is still on the inputs.
    assign base_c = accept_c ? bus.cfg_ub_base : base_q;
    assign len_c  = accept_c ? bus.cfg_len     : len_q;
    assign slot_c = accept_c ? bus.cfg_w_slot  : slot_q;
    assign cnt_c  = accept_c ? '0              : rd_cnt_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic. A zero-length job has an empty delay line, so it
    // passes through DRAIN without spending a cycle there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (!bus.cfg_skip_wload)    state_d = ST_WLOAD0;
                    else if (bus.cfg_len == '0) state_d = ST_DONE;
                    else                        state_d = ST_STREAM;
                end
            end
            ST_WLOAD0: state_d = ST_WLOAD1;
            ST_WLOAD1: state_d = (len_q == '0) ? ST_DONE : ST_STREAM;
            // rd_cnt_q counts reads already issued, including this cycle's.
            ST_STREAM: if (rd_cnt_q == len_q) state_d = ST_DRAIN;
            ST_DRAIN:  if (!drain_pending_c)  state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so every output is a flop.
    always_comb begin
        busy_d          = 1'b0;
        done_d          = 1'b0;
        weight_reload_d = 1'b0;
        ub_rd_valid_d   = 1'b0;
        wfifo_addr_d    = '0;
        ub_rd_addr_d    = '0;
        busy_d          = (state_d != ST_IDLE);
        done_d          = (state_d == ST_DONE);
        weight_reload_d = (state_d == ST_WLOAD1);
        if ((state_d == ST_WLOAD0) || (state_d == ST_WLOAD1)) begin
            wfifo_addr_d = slot_c;
        end
        if (state_d == ST_STREAM) begin
            ub_rd_valid_d = 1'b1;
            ub_rd_addr_d  = base_c + cnt_c;   // wraps modulo 2^AW
        end
    end

    // Output registers, job configuration and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            weight_reload_q <= 1'b0;
            ub_rd_valid_q   <= 1'b0;
            wfifo_addr_q    <= '0;
            ub_rd_addr_q    <= '0;
            base_q          <= '0;
            len_q           <= '0;
            slot_q          <= '0;
            rd_cnt_q        <= '0;
            res_addr_q      <= '0;
        end else begin
            busy_q          <= busy_d;
            done_q          <= done_d;
            weight_reload_q <= weight_reload_d;
            ub_rd_valid_q   <= ub_rd_valid_d;
            wfifo_addr_q    <= wfifo_addr_d;
            ub_rd_addr_q    <= ub_rd_addr_d;
            if (accept_c) begin
                base_q <= bus.cfg_ub_base;
                len_q  <= bus.cfg_len;
                slot_q <= bus.cfg_w_slot;
            end
            rd_cnt_q <= ub_rd_valid_d ? (cnt_c + AW'(1)) : cnt_c;
            if (accept_c)      res_addr_q <= '0;
            else if (res_we_c) res_addr_q <= res_addr_q + AW'(1);
        end
    end

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay_line (
        .clk         (clk),
        .clr         (rst),
        .in_valid    (ub_rd_valid_q),
        .out_valid   (res_we_c),
        .any_valid_c (drain_pending_c)
    );

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.weight_reload = weight_reload_q;
    assign bus.wfifo_addr    = wfifo_addr_q;
    assign bus.ub_rd_valid   = ub_rd_valid_q;
    assign bus.ub_rd_addr    = ub_rd_addr_q;
    assign bus.res_we        = res_we_c;
    assign bus.res_addr      = res_addr_q;

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Directed bench for vec_mul_sequencer with PIPE_LAT=4, 10-bit addresses and
// 2-bit weight slots. Cycle k is the interval after the k-th rising edge;
// inputs are driven and outputs sampled on the falling edge.
module tb_vec_mul_sequencer;
    import vec_mul_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned WW = 2;
    localparam int unsigned PL = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vec_mul_sequencer_if #(.ADDRESSSIZE(AW), .ADDRESSSIZE_fifo(WW)) bus ();

    vec_mul_sequencer #(
        .ADDRESSSIZE      (AW),
        .ADDRESSSIZE_fifo (WW),
        .PIPE_LAT         (PL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int rd_q[$];
    int res_q[$];
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int got[$], input int exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check($sformatf("%s_%0d", tag, i), 32'(got[i]), 32'(exp[i]));
        end
    endtask

    // Configuration applied after accept; must never influence the running job.
    task automatic drive_garbage_cfg();
        bus.cfg_ub_base    = AW'(100);
        bus.cfg_len        = AW'(7);
        bus.cfg_w_slot     = WW'(1);
        bus.cfg_skip_wload = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(bus.busy), 0);
        check({tag, "_done"},   32'(bus.done), 0);
        check({tag, "_wfifo"},  32'(bus.wfifo_addr), 0);
        check({tag, "_reload"}, 32'(bus.weight_reload), 0);
        check({tag, "_rdv"},    32'(bus.ub_rd_valid), 0);
        check({tag, "_rda"},    32'(bus.ub_rd_addr), 0);
        check({tag, "_we"},     32'(bus.res_we), 0);
        check({tag, "_resa"},   32'(bus.res_addr), 0);
    endtask

    // Starts a job in the current cycle (cycle 0) and checks every output for
    // cycles 1..done+extra against the expected job timeline.
    task automatic run_job(input string name, input int base, input int len, input int slot,
                           input bit skip, input bit hold, input int extra);
        int off       = skip ? 2 : 0;
        int first_rd  = 3 - off;
        int first_res = 3 + int'(PL) - off;
        int done_c    = (len == 0) ? (3 - off) : (3 + len + int'(PL) - off);
        bit exp_rd, exp_res;
        rd_q.delete();
        res_q.delete();
        check({name, "_c0_busy"}, 32'(bus.busy), 0);
        bus.cfg_ub_base    = AW'(base);
        bus.cfg_len        = AW'(len);
        bus.cfg_w_slot     = WW'(slot);
        bus.cfg_skip_wload = skip;
        bus.start          = 1'b1;
        for (int k = 1; k <= done_c + extra; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_rd  = (len > 0) && (k >= first_rd)  && (k < first_rd + len);
            exp_res = (len > 0) && (k >= first_res) && (k < first_res + len);
            check($sformatf("%s_c%0d_busy", name, k), 32'(bus.busy), 32'(k <= done_c));
            check($sformatf("%s_c%0d_done", name, k), 32'(bus.done), 32'(k == done_c));
            check($sformatf("%s_c%0d_reload", name, k), 32'(bus.weight_reload),
                  32'(!skip && (k == 2)));
            check($sformatf("%s_c%0d_wfifo", name, k), 32'(bus.wfifo_addr),
                  (!skip && (k == 1 || k == 2)) ? 32'(slot) : 32'd0);
            check($sformatf("%s_c%0d_rdv", name, k), 32'(bus.ub_rd_valid), 32'(exp_rd));
            check($sformatf("%s_c%0d_rda", name, k), 32'(bus.ub_rd_addr),
                  exp_rd ? 32'((base + k - first_rd) % 1024) : 32'd0);
            check($sformatf("%s_c%0d_we", name, k), 32'(bus.res_we), 32'(exp_res));
            if (exp_res) begin
                check($sformatf("%s_c%0d_resa", name, k), 32'(bus.res_addr),
                      32'(k - first_res));
            end
            if (bus.ub_rd_valid) rd_q.push_back(int'(bus.ub_rd_addr));
            if (bus.res_we)      res_q.push_back(int'(bus.res_addr));
            if (k == 1) begin
                if (!hold) bus.start = 1'b0;
                drive_garbage_cfg();
            end
        end
    endtask

    initial begin
        int done_at;
        int we_cnt;

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.cfg_ub_base    = '0;
        bus.cfg_len        = '0;
        bus.cfg_w_slot     = '0;
        bus.cfg_skip_wload = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Basic job
        run_job("basic", 5, 3, 2, 1'b0, 1'b0, 2);
        exp_q = '{5, 6, 7};
        check_seq("basic_rd", rd_q, exp_q);
        exp_q = '{0, 1, 2};
        check_seq("basic_res", res_q, exp_q);

        // Address wrap
        run_job("wrap", 1022, 4, 1, 1'b0, 1'b0, 2);
        exp_q = '{1022, 1023, 0, 1};
        check_seq("wrap_rd", rd_q, exp_q);
        exp_q = '{0, 1, 2, 3};
        check_seq("wrap_res", res_q, exp_q);

        // Zero length, with and without weight load
        run_job("zero", 9, 0, 3, 1'b0, 1'b0, 3);
        check("zero_nrd", 32'(rd_q.size()), 0);
        check("zero_nres", 32'(res_q.size()), 0);
        run_job("zero_skip", 9, 0, 3, 1'b1, 1'b0, 3);
        check("zero_skip_nrd", 32'(rd_q.size()), 0);

        // Weight reuse
        run_job("reuse", 0, 3, 0, 1'b1, 1'b0, 2);
        exp_q = '{0, 1, 2};
        check_seq("reuse_rd", rd_q, exp_q);

        // Start held through the job: second accept at the cycle after done
        // (cycle 11) picks up the garbage cfg: skip=1, base=100, len=7.
        run_job("hold", 5, 3, 2, 1'b0, 1'b1, 1);
        @(posedge clk);
        @(negedge clk);
        check("hold2_busy", 32'(bus.busy), 1);
        check("hold2_rdv", 32'(bus.ub_rd_valid), 1);
        check("hold2_rda", 32'(bus.ub_rd_addr), 100);
        check("hold2_reload", 32'(bus.weight_reload), 0);
        bus.start = 1'b0;
        done_at = -1;
        we_cnt  = 0;
        for (int c = 13; c <= 60; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done && done_at < 0) done_at = c;
            if (bus.res_we) we_cnt++;
        end
        check("hold2_done_cycle", 32'(done_at), 23);
        check("hold2_we_cnt", 32'(we_cnt), 7);
        check("hold2_idle", 32'(bus.busy), 0);

        // Reset in the middle of STREAM
        bus.cfg_ub_base    = AW'(5);
        bus.cfg_len        = AW'(3);
        bus.cfg_w_slot     = WW'(2);
        bus.cfg_skip_wload = 1'b0;
        bus.start          = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
        end
        check("rstmid_c4_rda", 32'(bus.ub_rd_addr), 6);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rstmid_c5");
        rst = 1'b0;
        we_cnt  = 0;
        done_at = 0;
        for (int k = 6; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.res_we) we_cnt++;
            if (bus.done || bus.busy) done_at++;
        end
        check("rstmid_no_we", 32'(we_cnt), 0);
        check("rstmid_no_done", 32'(done_at), 0);
        run_job("after_rst", 5, 3, 2, 1'b0, 1'b0, 2);
        exp_q = '{0, 1, 2};
        check_seq("after_rst_res", res_q, exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
